// File: rtl/player_ctrl_pkg.sv
// Shared types for the player controller: FSM encoding, shot offset, counter sizing.
// Pure declarations, no logic, no latency, no backpressure.
package player_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_ALIVE     = 2'd0,
        ST_DYING     = 2'd1,
        ST_GAME_OVER = 2'd2
    } state_t;

    localparam int SHOT_X_OFFSET = 0;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/player_ctrl_frame_counter.sv
// Loadable down-counter that steps once per dec pulse and saturates at zero.
// Latency 1 (count updates on the next edge); no backpressure, load beats dec.
module frame_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/player_ctrl.sv
// Player ship: per-frame movement, shot cooldown, and lives/respawn/game-over FSM.
// Latency 1 from frame/hit to outputs; no backpressure, every frame and hit is consumed.
module player_ctrl
    import player_ctrl_pkg::*;
#(
    parameter int COORD_W        = 10,
    parameter int START_X        = 304,
    parameter int START_Y        = 440,
    parameter int MIN_X          = 0,
    parameter int MAX_X          = 608,
    parameter int STEP           = 2,
    parameter int FIRE_COOLDOWN  = 30,
    parameter int RESPAWN_FRAMES = 120,
    parameter int LIVES          = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       frame,
    input  logic                       left,
    input  logic                       right,
    input  logic                       fire,
    input  logic                       hit,
    output logic [COORD_W-1:0]         player_x,
    output logic [COORD_W-1:0]         player_y,
    output logic                       alive,
    output logic                       shot_req,
    output logic [COORD_W-1:0]         shot_x,
    output logic [$clog2(LIVES+1)-1:0] lives_left,
    output logic                       game_over
);

    localparam int LW   = $clog2(LIVES + 1);
    localparam int XW   = COORD_W + 1;
    localparam int CD_W = cnt_width(FIRE_COOLDOWN);
    localparam int RS_W = cnt_width(RESPAWN_FRAMES);

    localparam logic [XW-1:0] MIN_E  = XW'(MIN_X);
    localparam logic [XW-1:0] MAX_E  = XW'(MAX_X);
    localparam logic [XW-1:0] STEP_E = XW'(STEP);

    state_t state, state_nxt;

    logic [COORD_W-1:0] x_q, x_nxt;
    logic [COORD_W-1:0] shot_x_q, shot_x_nxt;
    logic               shot_q, shot_nxt;
    logic [LW-1:0]      lives_q, lives_nxt;

    logic [CD_W-1:0]    cd_cnt, cd_load_val;
    logic               cd_load, cd_dec;
    logic [RS_W-1:0]    rs_cnt;
    logic               rs_load, rs_dec;

    logic               take_hit, alive_frame, dying_frame, respawn_done, fire_ok;
    logic [XW-1:0]      x_ext, x_left, x_right;

    assign take_hit     = (state == ST_ALIVE) && hit;
    assign alive_frame  = (state == ST_ALIVE) && frame && !hit;
    assign dying_frame  = (state == ST_DYING) && frame;
    // <= 1 rather than == 1 so a zero-length respawn cannot strand the FSM in DYING
    assign respawn_done = dying_frame && (rs_cnt <= RS_W'(1));
    assign fire_ok      = alive_frame && fire && (cd_cnt == '0);

    assign x_ext   = {1'b0, x_q};
    assign x_left  = (x_ext < MIN_E + STEP_E) ? MIN_E : x_ext - STEP_E;
    assign x_right = (x_ext + STEP_E > MAX_E) ? MAX_E : x_ext + STEP_E;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_ALIVE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_ALIVE: begin
                if (hit) begin
                    state_nxt = (lives_q == LW'(1)) ? ST_GAME_OVER : ST_DYING;
                end
            end
            ST_DYING: begin
                if (respawn_done) begin
                    state_nxt = ST_ALIVE;
                end
            end
            ST_GAME_OVER: state_nxt = ST_GAME_OVER;
            default:      state_nxt = ST_ALIVE;
        endcase
    end

    always_comb begin
        x_nxt       = x_q;
        shot_nxt    = 1'b0;
        shot_x_nxt  = shot_x_q;
        lives_nxt   = lives_q;
        cd_load     = 1'b0;
        cd_load_val = CD_W'(FIRE_COOLDOWN);
        cd_dec      = 1'b0;
        rs_load     = 1'b0;
        rs_dec      = 1'b0;
        unique case (state)
            ST_ALIVE: begin
                if (hit) begin
                    lives_nxt = lives_q - LW'(1);
                    rs_load   = (lives_q != LW'(1));
                end else if (frame) begin
                    if (left && !right) begin
                        x_nxt = x_left[COORD_W-1:0];
                    end else if (right && !left) begin
                        x_nxt = x_right[COORD_W-1:0];
                    end
                    cd_dec = 1'b1;
                    if (fire_ok) begin
                        shot_nxt   = 1'b1;
                        shot_x_nxt = x_q + COORD_W'(SHOT_X_OFFSET);
                        cd_load    = 1'b1;
                    end
                end
            end
            ST_DYING: begin
                cd_dec = dying_frame;
                rs_dec = dying_frame;
                if (respawn_done) begin
                    x_nxt       = COORD_W'(START_X);
                    cd_load     = 1'b1;
                    cd_load_val = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q      <= COORD_W'(START_X);
            shot_q   <= 1'b0;
            shot_x_q <= '0;
            lives_q  <= LW'(LIVES);
        end else begin
            x_q      <= x_nxt;
            shot_q   <= shot_nxt;
            shot_x_q <= shot_x_nxt;
            lives_q  <= lives_nxt;
        end
    end

    frame_counter #(.W(CD_W)) u_cooldown (
        .clk      (clk),
        .rst      (rst),
        .load     (cd_load),
        .load_val (cd_load_val),
        .dec      (cd_dec),
        .count    (cd_cnt)
    );

    frame_counter #(.W(RS_W)) u_respawn (
        .clk      (clk),
        .rst      (rst),
        .load     (rs_load),
        .load_val (RS_W'(RESPAWN_FRAMES)),
        .dec      (rs_dec),
        .count    (rs_cnt)
    );

    assign player_x   = x_q;
    assign player_y   = COORD_W'(START_Y);
    assign alive      = (state == ST_ALIVE);
    assign game_over  = (state == ST_GAME_OVER);
    assign shot_req   = shot_q;
    assign shot_x     = shot_x_q;
    assign lives_left = lives_q;

endmodule

// File: doc/player_ctrl.md
# player_ctrl

Parametrised player controller for the space-invaders core. It moves the player ship once per video frame from the left/right buttons, clamped to a configurable horizontal range. It also rate-limits shots with a frame-based cooldown and tracks lives through a hit/respawn/game-over state machine. It sits between the debounced button inputs and the renderer/bullet logic, and runs on the pixel clock alongside the other game objects.

## Interface
- COORD_W, 10, width of coordinate outputs
- START_X, 304, spawn/respawn x (left edge of sprite)
- START_Y, 440, fixed y row
- MIN_X, 0, leftmost legal x
- MAX_X, 608, rightmost legal x (screen width minus sprite width)
- STEP, 2, pixels moved per frame
- FIRE_COOLDOWN, 30, frames between accepted shots
- RESPAWN_FRAMES, 120, frames spent in DYING
- LIVES, 3, lives at reset (≥1)

- clk  in  1  pixel clock
- rst  in  1  reset: synchronous, active-high
- frame  in  1  one-cycle pulse per video frame
- left, right, fire  in  1  debounced, level buttons
- hit  in  1  one-cycle pulse: player struck by enemy bullet
- player_x  out  COORD_W  ship x, registered
- player_y  out  COORD_W  ship y, constant START_Y
- alive  out  1  high in ALIVE only (renderer draws ship)
- shot_req  out  1  one-cycle pulse: launch bullet
- shot_x  out  COORD_W  bullet spawn x, valid with shot_req
- lives_left  out  $clog2(LIVES+1)  remaining lives
- game_over  out  1  high in GAME_OVER

## Operation
- States: ALIVE, DYING, GAME_OVER. Reset → ALIVE.
- Reset values: player_x=START_X, player_y=START_Y, alive=1, shot_req=0, shot_x=0, lives_left=LIVES, game_over=0, cooldown=0, respawn counter=0.
- ALIVE, on frame, hit=0:
  - Movement uses left/right sampled in that cycle. left&~right → x=max(x−STEP, MIN_X). right&~left → x=min(x+STEP, MAX_X). Both or neither → hold.
  - Clamp arithmetic is done in COORD_W+1 bits; no wrap-around below 0 or above MAX_X.
  - Fire: if fire=1 and cooldown=0 → shot_req=1, shot_x=x (pre-move value) plus a centring offset of 0, cooldown=FIRE_COOLDOWN. Otherwise, if cooldown>0, cooldown decrements.
  - Holding fire re-fires every FIRE_COOLDOWN+1 frames.
- ALIVE, hit=1 on any cycle, including a frame cycle. Hit wins: no move, no shot that cycle.
  - lives_left decrements.
  - If the new value is 0 → GAME_OVER. Otherwise → DYING with counter=RESPAWN_FRAMES.
  - alive drops in the same update.
- DYING: buttons are ignored and hit is ignored. Each frame decrements the counter; the cooldown also keeps decrementing. Reaching 0 → ALIVE, with player_x=START_X and cooldown=0.
- GAME_OVER: absorbing until rst. All inputs are ignored, and player_x holds its last value.
- Between frame pulses, no state changes except on hit.

## Timing
- All outputs are registered. Effects of a frame or hit cycle appear on the outputs the following cycle (latency 1).
- shot_req is high for exactly one cycle, coincident with the updated player_x.
- rst asserted in any state overrides every other input that cycle. Outputs take reset values at the next edge, and any pending shot_req is cancelled.
- A frame pulse arriving on consecutive cycles is legal. Each pulse counts as one frame.

## Structure
- Shared package/constants file (existing `constants.v`): PLAYER_START_X/Y, PLAYER_STEP, screen and sprite widths, and the state encoding localparams (ALIVE=2'd0, DYING=2'd1, GAME_OVER=2'd2).
- Optional sub-module `frame_counter` (load, decrement on frame, zero flag). It is instantiated twice: once for the cooldown and once for respawn.

## Test plan
- Reset, then hold right for 400 frames (STEP=2, MAX_X=608) → player_x climbs 304→608 by frame 152, then stays at 608; no overflow.
- Hold left from x=304 with MIN_X=0 → x reaches 0 at frame 152 and holds. Both buttons held → x unchanged.
- Hold fire for 100 frames → shot_req pulses at frames 0, 31, 62, 93. Each pulse lasts 1 cycle, and shot_x equals player_x before that frame's move.
- Hit coincident with frame while right+fire are held → no move, no shot, lives 3→2, alive=0. After 120 frames the block returns to ALIVE with x=304.
- Three hits, each after respawn → lives 3→2→1→0, game_over=1. Further hit/frame/buttons produce no change; rst restores lives=3 and ALIVE.
- rst asserted mid-DYING (counter=50) → next cycle all reset values, ALIVE, and no residual respawn.
